al_buckeye_readback: RTL and testbench
======================================

# al_buckeye_readback

Deserializes the serial return stream from the Buckeye shift-register chain, packs it into 16-bit words, and buffers the words for readback over the BPI/JTAG register path. It is the receive end of the Buckeye load interface. It sits beside the Buckeye loader on the same 1 MHz shift clock and enable, samples the chain output on the opposite edge from the one that drives data, and lets firmware verify what the chain actually holds.

## Interface
- DEPTH_LOG2, 4, log2 of readback FIFO depth in 16-bit words (default 16 words)
- CLK40  in  1  system clock; all logic on its rising edge
- RST  in  1  asynchronous, active-high reset
- CLK1MHZ  in  1  Buckeye shift clock, derived from CLK40; treated as data, never used as a clock
- SHCK_ENA  in  1  shift-clock enable from the loader; a bit is valid only while it is high
- SDATA_IN  in  1  serial output of the last Buckeye in the chain
- START  in  1  one-cycle pulse: clear the block and arm a capture
- BIT_CNT  in  12  number of bits to capture; sampled on START
- RD_EN  in  1  pop the FIFO head; ignored while EMPTY
- DOUT  out  16  FIFO head, first-word-fall-through; valid when EMPTY=0
- EMPTY  out  1  FIFO empty
- FULL  out  1  FIFO holds 2^DEPTH_LOG2 words
- WORDS  out  DEPTH_LOG2+1  current FIFO occupancy
- OVFL  out  1  sticky; a word was dropped because the FIFO was full
- BUSY  out  1  high in ARMED, CAPTURE, or FLUSH
- DONE  out  1  sticky; capture complete
- CHKSUM  out  16  running XOR of pushed words (see Configuration)

## Operation
- Synchronizers: CLK1MHZ, SHCK_ENA, and SDATA_IN each pass through 2 flops (s1, s2). A third flop s3 holds CLK1MHZ. The sample strobe is `smp = clk_s2 & ~clk_s3 & ena_s2`, which is the rising edge of CLK1MHZ; the loader drives data on the falling edge.
- Shift register: on smp, `sr <= {sdat_s2, sr[15:1]}` (LSB first, matching the loader). `bitcnt` (12 bits) and `wbit` (4 bits) both increment on smp.
- Word push: when the 16th bit of a word is sampled (wbit wraps 15→0), the assembled word is pushed the next cycle.
- States:
  - IDLE: on START, latch BIT_CNT, clear sr, bitcnt, wbit, OVFL, DONE, CHKSUM and the FIFO. If BIT_CNT=0, go to DONE_ST; otherwise go to ARMED.
  - ARMED: on the first smp, go to CAPTURE; that bit is captured.
  - CAPTURE: when bitcnt reaches the latched count, go to FLUSH.
  - FLUSH: if wbit≠0, push the partial word right-justified (`sr >> (16-wbit)`, upper bits 0). Then go to DONE_ST.
  - DONE_ST: DONE=1, BUSY=0. START restarts the capture.
- START in any state aborts the current capture and restarts as described for IDLE; a partial word is discarded.
- Strobes (smp) outside ARMED/CAPTURE are ignored.
- FIFO: depth 2^DEPTH_LOG2, pointers wrap modulo depth, occupancy counter has DEPTH_LOG2+1 bits.
  - Push while FULL and no simultaneous pop: the word is dropped and OVFL is set.
  - Push while FULL with RD_EN high in the same cycle: both the push and the pop occur, and occupancy stays unchanged.
  - Pop while EMPTY: no effect.

## Timing
- Reset values: DOUT=0, EMPTY=1, FULL=0, WORDS=0, OVFL=0, BUSY=0, DONE=0, CHKSUM=0, state IDLE.
- smp is asserted 3 CLK40 cycles after the CLK1MHZ rising edge reaches the s1 input.
- Push latency: the word enters the FIFO 1 cycle after the smp of its 16th bit. EMPTY falls and DOUT is valid on the following cycle.
- RD_EN pop: DOUT shows the next word, or EMPTY rises, in the cycle after RD_EN.
- DONE rises 1 cycle after FLUSH, so 2–3 cycles after the last smp.
- START with BIT_CNT=0: DONE rises 2 cycles after START.

## Configuration
- AL_BKY_RB_CHKSUM_EN defined: CHKSUM is the XOR of every word pushed, including words dropped by overflow. It is updated 1 cycle after each push and cleared by START.
- AL_BKY_RB_CHKSUM_EN undefined: CHKSUM is tied to 16'h0000 and no checksum logic is built.

## Test plan
- BIT_CNT=32, SDATA_IN drives 16'hA5C3 then 16'h1234, LSB first, under SHCK_ENA → DOUT reads 16'hA5C3 then 16'h1234, DONE=1, OVFL=0, CHKSUM=16'hB7F7 with the macro defined.
- BIT_CNT=20 with 20 bits of 1 → words 16'hFFFF then 16'h000F; WORDS=2 before any pop.
- DEPTH_LOG2=2, BIT_CNT=96, no pops → WORDS=4, FULL=1, OVFL=1. Repeat with RD_EN held high on every push cycle → OVFL=0.
- SHCK_ENA low while CLK1MHZ toggles for 50 µs, then 16 enabled bits of 16'h8001 with BIT_CNT=16 → exactly one word, 16'h8001.
- START mid-capture after 10 bits, then a fresh 16-bit stream of 16'h00FF → only 16'h00FF is captured. Assert RST mid-capture → all outputs return to their reset values.
- BIT_CNT=0 START → DONE high 2 cycles later, EMPTY=1, BUSY never asserted.

Source files
------------

// File: rtl/al_buckeye_readback_if.sv
// Bus bundle for al_buckeye_readback: Buckeye serial return inputs, capture
// control, and the FIFO readback/status outputs.
interface al_buckeye_readback_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  CLK1MHZ;
    logic                  SHCK_ENA;
    logic                  SDATA_IN;
    logic                  START;
    logic [11:0]           BIT_CNT;
    logic                  RD_EN;
    logic [15:0]           DOUT;
    logic                  EMPTY;
    logic                  FULL;
    logic [DEPTH_LOG2:0]   WORDS;
    logic                  OVFL;
    logic                  BUSY;
    logic                  DONE;
    logic [15:0]           CHKSUM;

    modport master (
        output CLK1MHZ, SHCK_ENA, SDATA_IN, START, BIT_CNT, RD_EN,
        input  DOUT, EMPTY, FULL, WORDS, OVFL, BUSY, DONE, CHKSUM
    );

    modport slave (
        input  CLK1MHZ, SHCK_ENA, SDATA_IN, START, BIT_CNT, RD_EN,
        output DOUT, EMPTY, FULL, WORDS, OVFL, BUSY, DONE, CHKSUM
    );
endinterface

// File: rtl/al_buckeye_readback.sv
// Buckeye chain readback: samples the serial return stream, packs LSB-first
// 16-bit words into a FWFT FIFO. Optional XOR checksum via AL_BKY_RB_CHKSUM_EN.
module al_buckeye_readback #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                 CLK40,
    input  logic                 RST,
    al_buckeye_readback_if.slave bus
);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        FLUSH,
        DONE_ST
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers; CLK1MHZ is data here, its edge is found by s2/s3.
    // ------------------------------------------------------------------
    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic ena_s1_q, ena_s2_q;
    logic dat_s1_q, dat_s2_q;
    logic smp;

    // NOTE: every clocked block uses <= so all flops update from pre-edge values.
    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            clk_s1_q <= 1'b0;
            clk_s2_q <= 1'b0;
            clk_s3_q <= 1'b0;
            ena_s1_q <= 1'b0;
            ena_s2_q <= 1'b0;
            dat_s1_q <= 1'b0;
            dat_s2_q <= 1'b0;
        end else begin
            clk_s1_q <= bus.CLK1MHZ;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            ena_s1_q <= bus.SHCK_ENA;
            ena_s2_q <= ena_s1_q;
            dat_s1_q <= bus.SDATA_IN;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign smp = clk_s2_q & ~clk_s3_q & ena_s2_q;

    // ------------------------------------------------------------------
    // Capture FSM and word assembly
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [11:0] cnt_q;
    logic [11:0] bitcnt_q;
    logic [3:0]  wbit_q;
    logic [15:0] sr_q;
    logic        push_q;
    logic [15:0] push_data_q;
    logic        busy_q;
    logic        done_q;

    logic [15:0] sr_shift;
    logic [15:0] flush_word;

    assign sr_shift   = {dat_s2_q, sr_q[15:1]};
    assign flush_word = sr_q >> (5'd16 - {1'b0, wbit_q});

    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitcnt_q    <= '0;
            wbit_q      <= '0;
            sr_q        <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (bus.START) begin
                // Restart from any state; a partially assembled word is lost.
                cnt_q    <= bus.BIT_CNT;
                bitcnt_q <= '0;
                wbit_q   <= '0;
                sr_q     <= '0;
                done_q   <= 1'b0;
                if (bus.BIT_CNT == 12'd0) begin
                    state_q <= DONE_ST;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= ARMED;
                    busy_q  <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: ;
                    ARMED, CAPTURE: begin
                        if (state_q == CAPTURE && bitcnt_q == cnt_q) begin
                            state_q <= FLUSH;
                        end else if (smp) begin
                            state_q  <= CAPTURE;
                            sr_q     <= sr_shift;
                            bitcnt_q <= bitcnt_q + 12'd1;
                            wbit_q   <= wbit_q + 4'd1;
                            if (wbit_q == 4'd15) begin
                                push_q      <= 1'b1;
                                push_data_q <= sr_shift;
                            end
                        end
                    end
                    FLUSH: begin
                        if (wbit_q != 4'd0) begin
                            push_q      <= 1'b1;
                            push_data_q <= flush_word;
                        end
                        state_q <= DONE_ST;
                        busy_q  <= 1'b0;
                    end
                    DONE_ST: done_q <= 1'b1;
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Readback FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [15:0]           mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovfl_q, ovfl_d;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  wr_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign pop   = bus.RD_EN & ~empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign wr_en = push_q & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovfl_d   = ovfl_q;
        if (bus.START) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovfl_d   = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{DEPTH_LOG2{1'b0}}, wr_en}
                              - {{DEPTH_LOG2{1'b0}}, pop};
            if (push_q && !wr_en) ovfl_d = 1'b1;
        end
    end

    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovfl_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovfl_q   <= ovfl_d;
        end
    end

    // NOTE: storage has no reset; DOUT is forced to zero while empty instead.
    always_ff @(posedge CLK40) begin
        if (wr_en) mem[wr_ptr_q] <= push_data_q;
    end

`ifdef AL_BKY_RB_CHKSUM_EN
    logic [15:0] chk_q;

    // Dropped words still count: the sum reflects what the chain returned.
    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            chk_q <= '0;
        end else if (bus.START) begin
            chk_q <= '0;
        end else if (push_q) begin
            chk_q <= chk_q ^ push_data_q;
        end
    end

    assign bus.CHKSUM = chk_q;
`else
    assign bus.CHKSUM = 16'h0000;
`endif

    assign bus.DOUT  = empty ? 16'h0000 : mem[rd_ptr_q];
    assign bus.EMPTY = empty;
    assign bus.FULL  = full;
    assign bus.WORDS = count_q;
    assign bus.OVFL  = ovfl_q;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;

endmodule

// File: tb/tb_al_buckeye_readback.sv
// Randomized bench for al_buckeye_readback: a 16-deep and a 4-deep instance
// share the serial stimulus; a queue-based word model predicts the FIFO contents.
module tb_al_buckeye_readback;
    logic        clk40 = 1'b0;
    logic        rst   = 1'b1;
    logic        clk1  = 1'b0;
    logic        ena   = 1'b0;
    logic        sdat  = 1'b0;
    logic        start = 1'b0;
    logic [11:0] bit_cnt = '0;
    logic        rd_a  = 1'b0;
    logic        rd_b  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic bit_q[$];
    logic en_q[$];

    al_buckeye_readback_if #(.DEPTH_LOG2(4)) bus_a ();
    al_buckeye_readback_if #(.DEPTH_LOG2(2)) bus_b ();

    assign bus_a.CLK1MHZ  = clk1;
    assign bus_a.SHCK_ENA = ena;
    assign bus_a.SDATA_IN = sdat;
    assign bus_a.START    = start;
    assign bus_a.BIT_CNT  = bit_cnt;
    assign bus_a.RD_EN    = rd_a;
    assign bus_b.CLK1MHZ  = clk1;
    assign bus_b.SHCK_ENA = ena;
    assign bus_b.SDATA_IN = sdat;
    assign bus_b.START    = start;
    assign bus_b.BIT_CNT  = bit_cnt;
    assign bus_b.RD_EN    = rd_b;

    al_buckeye_readback #(.DEPTH_LOG2(4)) dut_a (
        .CLK40 (clk40),
        .RST   (rst),
        .bus   (bus_a.slave)
    );

    al_buckeye_readback #(.DEPTH_LOG2(2)) dut_b (
        .CLK40 (clk40),
        .RST   (rst),
        .bus   (bus_b.slave)
    );

    always #5 clk40 = ~clk40;

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_reset(input string p, input logic [15:0] dout, input logic empty,
                               input logic full, input int words, input logic ovfl,
                               input logic busy, input logic done, input logic [15:0] chk);
        check({p, "_dout"},   dout,  16'h0);
        check({p, "_empty"},  empty, 1'b1);
        check({p, "_full"},   full,  1'b0);
        check({p, "_words"},  words, 0);
        check({p, "_ovfl"},   ovfl,  1'b0);
        check({p, "_busy"},   busy,  1'b0);
        check({p, "_done"},   done,  1'b0);
        check({p, "_chksum"}, chk,   16'h0);
    endtask

    // One Buckeye shift period: data changes with the falling edge, sampled on the rising.
    task automatic send_bit(input logic b, input logic e);
        clk1 = 1'b0;
        sdat = b;
        ena  = e;
        repeat (10) @(negedge clk40);
        clk1 = 1'b1;
        repeat (10) @(negedge clk40);
    endtask

    task automatic start_capture(input int n);
        bit_cnt = 12'(n);
        start   = 1'b1;
        @(negedge clk40);
        start   = 1'b0;
    endtask

    task automatic add_word(input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            bit_q.push_back(w[i]);
            en_q.push_back(1'b1);
        end
    endtask

    task automatic clear_stream();
        bit_q.delete();
        en_q.delete();
    endtask

    task automatic pop_a();
        rd_a = 1'b1;
        @(negedge clk40);
        rd_a = 1'b0;
    endtask

    task automatic pop_b();
        rd_b = 1'b1;
        @(negedge clk40);
        rd_b = 1'b0;
    endtask

    // Start a capture of n bits, play the queued stream, then compare both instances.
    task automatic do_run(input string name, input int n, input logic hold_b);
        logic [15:0] words[$];
        logic [15:0] cur;
        logic [15:0] exp_chk;
        int          k;
        int          kept_a, kept_b;
        logic        ovfl_a, ovfl_b;
        int          waited;

        cur = '0;
        k   = 0;
        for (int i = 0; i < bit_q.size(); i++) begin
            if (en_q[i] && k < n) begin
                cur[k % 16] = bit_q[i];
                k++;
                if (k % 16 == 0) begin
                    words.push_back(cur);
                    cur = '0;
                end
            end
        end
        if (k % 16 != 0) words.push_back(cur);
        exp_chk = '0;
`ifdef AL_BKY_RB_CHKSUM_EN
        foreach (words[i]) exp_chk ^= words[i];
`endif
        kept_a = (words.size() > 16) ? 16 : words.size();
        ovfl_a = (words.size() > 16);
        kept_b = hold_b ? 0 : ((words.size() > 4) ? 4 : words.size());
        ovfl_b = hold_b ? 1'b0 : (words.size() > 4);

        rd_b = hold_b;
        start_capture(n);
        for (int i = 0; i < bit_q.size(); i++) send_bit(bit_q[i], en_q[i]);
        ena = 1'b0;

        waited = 0;
        while (!bus_a.DONE && waited < 200) begin
            @(negedge clk40);
            waited++;
        end
        check({name, "_done_wait"}, bus_a.DONE, 1'b1);
        repeat (3) @(negedge clk40);
        rd_b = 1'b0;
        @(negedge clk40);

        check({name, "_a_busy"},   bus_a.BUSY,   1'b0);
        check({name, "_a_words"},  bus_a.WORDS,  kept_a);
        check({name, "_a_full"},   bus_a.FULL,   kept_a == 16);
        check({name, "_a_ovfl"},   bus_a.OVFL,   ovfl_a);
        check({name, "_a_chksum"}, bus_a.CHKSUM, exp_chk);
        for (int i = 0; i < kept_a; i++) begin
            check({name, "_a_dout"},  bus_a.DOUT,  words[i]);
            check({name, "_a_empty"}, bus_a.EMPTY, 1'b0);
            pop_a();
        end
        check({name, "_a_empty_end"}, bus_a.EMPTY, 1'b1);

        check({name, "_b_done"},   bus_b.DONE,   1'b1);
        check({name, "_b_words"},  bus_b.WORDS,  kept_b);
        check({name, "_b_full"},   bus_b.FULL,   kept_b == 4);
        check({name, "_b_ovfl"},   bus_b.OVFL,   ovfl_b);
        check({name, "_b_chksum"}, bus_b.CHKSUM, exp_chk);
        for (int i = 0; i < kept_b; i++) begin
            check({name, "_b_dout"}, bus_b.DOUT, words[i]);
            pop_b();
        end
        check({name, "_b_empty_end"}, bus_b.EMPTY, 1'b1);
    endtask

    initial begin
        logic busy_seen;
        int   n;

        repeat (3) @(negedge clk40);
        check_reset("rst_a", bus_a.DOUT, bus_a.EMPTY, bus_a.FULL, int'(bus_a.WORDS),
                    bus_a.OVFL, bus_a.BUSY, bus_a.DONE, bus_a.CHKSUM);
        check_reset("rst_b", bus_b.DOUT, bus_b.EMPTY, bus_b.FULL, int'(bus_b.WORDS),
                    bus_b.OVFL, bus_b.BUSY, bus_b.DONE, bus_b.CHKSUM);
        rst = 1'b0;
        repeat (3) @(negedge clk40);

        clear_stream();
        add_word(16'hA5C3);
        add_word(16'h1234);
        do_run("two_words", 32, 1'b0);

        clear_stream();
        for (int i = 0; i < 20; i++) begin
            bit_q.push_back(1'b1);
            en_q.push_back(1'b1);
        end
        do_run("ones20", 20, 1'b0);

        clear_stream();
        for (int i = 0; i < 6; i++) add_word(16'($urandom));
        do_run("ovfl96", 96, 1'b0);
        do_run("ovfl96_rd", 96, 1'b1);

        clear_stream();
        for (int i = 0; i < 50; i++) begin
            bit_q.push_back(1'($urandom));
            en_q.push_back(1'b0);
        end
        add_word(16'h8001);
        do_run("ena_gap", 16, 1'b0);

        // Abort after 10 bits; the restart must discard the partial word.
        start_capture(32);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
        check("abort_busy", bus_a.BUSY, 1'b1);
        clear_stream();
        add_word(16'h00FF);
        do_run("abort", 16, 1'b0);

        start_capture(40);
        for (int i = 0; i < 20; i++) send_bit(1'($urandom), 1'b1);
        ena = 1'b0;
        check("midrst_words_pre", bus_a.WORDS, 1);
        rst = 1'b1;
        @(negedge clk40);
        check_reset("midrst_a", bus_a.DOUT, bus_a.EMPTY, bus_a.FULL, int'(bus_a.WORDS),
                    bus_a.OVFL, bus_a.BUSY, bus_a.DONE, bus_a.CHKSUM);
        check_reset("midrst_b", bus_b.DOUT, bus_b.EMPTY, bus_b.FULL, int'(bus_b.WORDS),
                    bus_b.OVFL, bus_b.BUSY, bus_b.DONE, bus_b.CHKSUM);
        rst = 1'b0;
        repeat (3) @(negedge clk40);

        // Zero-length capture: straight to done, never busy.
        busy_seen = 1'b0;
        bit_cnt = 12'd0;
        start   = 1'b1;
        @(negedge clk40);
        start   = 1'b0;
        busy_seen |= bus_a.BUSY;
        check("zero_done_early", bus_a.DONE, 1'b0);
        @(negedge clk40);
        busy_seen |= bus_a.BUSY;
        check("zero_done", bus_a.DONE, 1'b1);
        check("zero_empty", bus_a.EMPTY, 1'b1);
        repeat (4) begin
            @(negedge clk40);
            busy_seen |= bus_a.BUSY;
        end
        check("zero_busy_never", busy_seen, 1'b0);

        for (int r = 0; r < 6; r++) begin
            clear_stream();
            n = $urandom_range(1, 70);
            for (int k = 0; k < n + 2; ) begin
                logic e;
                e = ($urandom_range(0, 4) != 0);
                bit_q.push_back(1'($urandom));
                en_q.push_back(e);
                if (e) k++;
            end
            do_run($sformatf("rand%0d", r), n, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
